proj_to_affine: RTL and testbench

Converts a projective x-coordinate (X : Z) over GF(p), with p = 2^255 − 19, into the affine value x = X·Z⁻¹ mod p. It sits downstream of the scalar-multiplication ladder and drives the shared EEA inverter (`ffi`) as its upstream operand source. It also consumes the inverse that `ffi` returns. The final multiply is a bit-serial interleaved modular multiplier.

---
 rtl/proj_to_affine_pkg.sv | 20 ++
 rtl/proj_to_affine_if.sv | 24 ++
 rtl/proj_to_affine_modmul_serial.sv | 57 +++++
 rtl/proj_to_affine.sv | 137 +++++++++++++
 tb/tb_proj_to_affine.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/proj_to_affine_pkg.sv
// Shared constants and state encoding for the projective-to-affine converter.
package p2a_pkg;

  localparam int unsigned WIDTH     = 255;
  localparam int unsigned MUL_STEPS = 255;

  // 2^255 - 19
  localparam logic [WIDTH-1:0] P = '1 - 255'd18;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    INV_REQ,
    INV_WAIT_LO,
    INV_WAIT_HI,
    MUL,
    OUT
  } state_t;

endpackage

// File: rtl/proj_to_affine_if.sv
// Point-in / affine-out handshake bundle of proj_to_affine.
interface proj_to_affine_if;
  import p2a_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] z_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x_aff;
  logic             inf;

  modport master (
    output in_valid, x_in, z_in, out_ready,
    input  in_ready, out_valid, x_aff, inf
  );

  modport slave (
    input  in_valid, x_in, z_in, out_ready,
    output in_ready, out_valid, x_aff, inf
  );

endinterface

// File: rtl/proj_to_affine_modmul_serial.sv
// Bit-serial interleaved multiplier mod P: result = a*b mod P, b scanned MSB first.
module modmul_serial
  import p2a_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  logic [WIDTH+1:0] acc;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [7:0]       cnt;
  logic             busy;

  function automatic logic [WIDTH+1:0] mod_step(input logic [WIDTH+1:0] acc_in,
                                                input logic [WIDTH-1:0] x,
                                                input logic             bit_in);
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] u;
    t = acc_in << 1;
    if (t >= {2'b00, P}) t = t - {2'b00, P};
    u = t + (bit_in ? {2'b00, x} : '0);
    if (u >= {2'b00, P}) u = u - {2'b00, P};
    return u;
  endfunction

  // Asserted during the final iteration so the caller can leave on the same edge.
  assign done   = busy && (cnt == 8'(MUL_STEPS - 1));
  assign result = acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc  <= '0;
      a_q  <= a;
      b_q  <= b;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= mod_step(acc, a_q, b_q[WIDTH-1]);
      b_q <= b_q << 1;
      cnt <= cnt + 8'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/proj_to_affine.sv
// Projective (X:Z) to affine x = X/Z mod P using the shared ffi inverter.
// Optional input reduction stage: define P2A_REDUCE_IN_EN.
module proj_to_affine
  import p2a_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  proj_to_affine_if.slave  bus,
  output logic [WIDTH-1:0] inv_a,
  input  logic [WIDTH-1:0] inv_res,
  input  logic             inv_valid,
  output logic             inv_rst
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] x_aff_q;
  logic             inf_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic             accept;
  logic             z_zero;
  logic             hit;
  logic             latch_in;
  logic             mul_start;
  logic             load_inv_a;
  logic             set_inf;
  logic             out_first;
  logic             out_fire;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;

  assign inv_rst       = ~rst_n;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_aff     = x_aff_q;
  assign bus.inf       = inf_q;

  assign accept = bus.in_valid && in_ready_q;
  assign z_zero = (z_q == '0) || (z_q == P);
  assign hit    = (z_q == inv_a) && inv_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef P2A_REDUCE_IN_EN
          state_next = REDUCE;
`else
          state_next = INV_REQ;
`endif
        end
      end
`ifdef P2A_REDUCE_IN_EN
      REDUCE:      state_next = INV_REQ;
`endif
      INV_REQ: begin
        if (z_zero)   state_next = OUT;
        else if (hit) state_next = MUL;
        else          state_next = INV_WAIT_LO;
      end
      INV_WAIT_LO: if (!inv_valid) state_next = INV_WAIT_HI;
      INV_WAIT_HI: if (inv_valid)  state_next = MUL;
      MUL:         if (mul_done)   state_next = OUT;
      OUT:         if (out_valid_q && bus.out_ready) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_in   = (state == IDLE) && accept;
    mul_start  = ((state == INV_REQ) && !z_zero && hit) ||
                 ((state == INV_WAIT_HI) && inv_valid);
    load_inv_a = (state == INV_REQ) && !z_zero && !hit;
    set_inf    = (state == INV_REQ) && z_zero;
    out_first  = (state == OUT) && !out_valid_q;
    out_fire   = (state == OUT) && out_valid_q && bus.out_ready;
  end

  // The inverse is captured by the multiplier itself on mul_start.
  modmul_serial u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (x_q),
    .b      (inv_res),
    .result (mul_res),
    .done   (mul_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      z_q         <= '0;
      inv_a       <= '0;
      x_aff_q     <= '0;
      inf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      in_ready_q <= (state_next == IDLE);
      if (latch_in) begin
        x_q <= bus.x_in;
        z_q <= bus.z_in;
      end
`ifdef P2A_REDUCE_IN_EN
      if (state == REDUCE) begin
        if (x_q >= P) x_q <= x_q - P;
        if (z_q >= P) z_q <= z_q - P;
      end
`endif
      if (load_inv_a) inv_a <= z_q;
      if (set_inf) begin
        inf_q   <= 1'b1;
        x_aff_q <= '0;
      end
      if (out_first) begin
        out_valid_q <= 1'b1;
        if (!inf_q) x_aff_q <= mul_res;
      end
      if (out_fire) begin
        out_valid_q <= 1'b0;
        inf_q       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proj_to_affine.sv
// Directed bench for proj_to_affine with a behavioural ffi model (stale valid window).
module tb_proj_to_affine;
  import p2a_pkg::*;

`ifdef P2A_REDUCE_IN_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] inv_a;
  logic [WIDTH-1:0] inv_res;
  logic             inv_valid;
  logic             inv_rst;

  int passed = 0;
  int total  = 0;

  logic [WIDTH-1:0] inv2;
  logic [WIDTH-1:0] inv3;
  logic [WIDTH+1:0] tmp3;
  logic [WIDTH-1:0] p_const;

  always #5 clk = ~clk;

  proj_to_affine_if bus ();

  proj_to_affine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .inv_a     (inv_a),
    .inv_res   (inv_res),
    .inv_valid (inv_valid),
    .inv_rst   (inv_rst)
  );

  // ffi model: stale valid for 2 cycles after operand change, low for 6, then result.
  logic [WIDTH-1:0] a_last;
  int               stale_cnt;
  int               lat_cnt;

  function automatic logic [WIDTH-1:0] model_inv(input logic [WIDTH-1:0] a);
    if (a == 255'd1) return 255'd1;
    if (a == 255'd2) return inv2;
    if (a == 255'd3) return inv3;
    return '0;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_last    = '0;
      stale_cnt = 0;
      lat_cnt   = 0;
      inv_valid = 1'b0;
      inv_res   = '0;
    end else if (inv_a != a_last) begin
      a_last    = inv_a;
      stale_cnt = 2;
      lat_cnt   = 6;
    end else if (stale_cnt > 0) begin
      stale_cnt = stale_cnt - 1;
      if (stale_cnt == 0) inv_valid = 1'b0;
    end else if (lat_cnt > 0) begin
      lat_cnt = lat_cnt - 1;
      if (lat_cnt == 0) begin
        inv_valid = 1'b1;
        inv_res   = model_inv(a_last);
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    bus.x_in     = x;
    bus.z_in     = z;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("accept", {255'd0, ok}, 256'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check("out_valid_seen", {255'd0, bus.out_valid}, 256'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("out_valid_drop", {255'd0, bus.out_valid}, 256'd0);
  endtask

  int lat;

  initial begin
    p_const = P;
    inv2 = (255'd1 << 254) - 255'd9;
    tmp3 = ({2'b00, p_const} << 1) + 257'd1;
    tmp3 = tmp3 / 3;
    inv3 = tmp3[WIDTH-1:0];

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.z_in      = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {255'd0, bus.in_ready},  256'd0);
    check("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
    check("rst_x_aff",     {1'b0, bus.x_aff},       256'd0);
    check("rst_inf",       {255'd0, bus.inf},       256'd0);
    check("rst_inv_a",     {1'b0, inv_a},           256'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("in_ready_pre", {255'd0, bus.in_ready}, 256'd0);
    @(posedge clk);
    #1 check("in_ready_up", {255'd0, bus.in_ready}, 256'd1);

    // X=5, Z=1
    accept(255'd5, 255'd1);
    wait_out(lat);
    check("x5z1_x_aff", {1'b0, bus.x_aff}, 256'd5);
    check("x5z1_inf",   {255'd0, bus.inf}, 256'd0);
    release_out();

    // X=1, Z=2 -> inverse of 2
    accept(255'd1, 255'd2);
    wait_out(lat);
    check("x1z2_x_aff", {1'b0, bus.x_aff}, {1'b0, inv2});
    check("x1z2_inv_a", {1'b0, inv_a}, 256'd2);
    release_out();

    // X=4, Z=2 cache hit
    accept(255'd4, 255'd2);
    wait_out(lat);
    check("hit_x_aff", {1'b0, bus.x_aff}, 256'd2);
    check("hit_lat",   256'(lat), 256'(257 + EXTRA));
    check("hit_inv_a", {1'b0, inv_a}, 256'd2);
    release_out();

    // Z=0 and Z=P -> infinity
    accept(255'd7, 255'd0);
    wait_out(lat);
    check("z0_inf",   {255'd0, bus.inf}, 256'd1);
    check("z0_x_aff", {1'b0, bus.x_aff}, 256'd0);
    check("z0_lat",   256'(lat), 256'(2 + EXTRA));
    check("z0_inv_a", {1'b0, inv_a}, 256'd2);
    release_out();
    check("inf_clear", {255'd0, bus.inf}, 256'd0);

    accept(255'd7, p_const);
    wait_out(lat);
    check("zp_inf",   {255'd0, bus.inf}, 256'd1);
    check("zp_x_aff", {1'b0, bus.x_aff}, 256'd0);
    check("zp_lat",   256'(lat), 256'(2 + EXTRA));
    check("zp_inv_a", {1'b0, inv_a}, 256'd2);
    release_out();

    // X=6, Z=3: stale inverse of 2 must be ignored; busy in_valid ignored; backpressure
    accept(255'd6, 255'd3);
    @(negedge clk);
    bus.x_in     = 255'd100;
    bus.z_in     = 255'd1;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("busy_in_ready", {255'd0, bus.in_ready}, 256'd0);
    end
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("stale_x_aff", {1'b0, bus.x_aff}, 256'd2);
    check("stale_inv_a", {1'b0, inv_a}, 256'd3);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {255'd0, bus.out_valid}, 256'd1);
      check("bp_x_aff",     {1'b0, bus.x_aff},       256'd2);
      check("bp_in_ready",  {255'd0, bus.in_ready},  256'd0);
    end
    release_out();

    // Reset pulse mid-multiply
    accept(255'd9, 255'd3);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {255'd0, bus.out_valid}, 256'd0);
    check("mrst_x_aff",     {1'b0, bus.x_aff},       256'd0);
    check("mrst_inf",       {255'd0, bus.inf},       256'd0);
    check("mrst_inv_a",     {1'b0, inv_a},           256'd0);
    check("mrst_in_ready",  {255'd0, bus.in_ready},  256'd0);
    @(negedge clk) rst_n = 1'b1;
    accept(255'd5, 255'd1);
    wait_out(lat);
    check("post_rst_x_aff", {1'b0, bus.x_aff}, 256'd5);
    release_out();

`ifdef P2A_REDUCE_IN_EN
    accept(p_const + 255'd5, 255'd1);
    wait_out(lat);
    check("reduce_x_aff", {1'b0, bus.x_aff}, 256'd5);
    release_out();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
